// File: rtl/led_scan_scheduler_pkg.sv
// Shared definitions for the LEDG scan scheduler: mode encodings, the SW speed
// multiplier table and the LED reset pattern.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_BOUNCE = 2'd0,
      MODE_ROT_L  = 2'd1,
      MODE_ROT_R  = 2'd2,
      MODE_PAUSED = 2'd3
   } mode_t;

   // Step period is BASE_DIV times the multiplier of the lowest set SW index.
   localparam int unsigned SPEED_MULT [0:9] = '{10, 9, 8, 7, 6, 5, 4, 3, 2, 1};
   localparam int unsigned DEFAULT_MULT     = 11;

   localparam logic [7:0] LED_RESET = 8'h01;

   function automatic logic is_one_hot(input logic [7:0] v);
      return (v != 8'h00) && ((v & (v - 8'd1)) == 8'h00);
   endfunction

   function automatic mode_t next_run_mode(input mode_t m);
      case (m)
         MODE_BOUNCE: return MODE_ROT_L;
         MODE_ROT_L:  return MODE_ROT_R;
         default:     return MODE_BOUNCE;
      endcase
   endfunction

endpackage

// File: rtl/led_scan_scheduler_if.sv
// Board-facing signal bundle of the scheduler: raw keys and switches in,
// LED pattern and step/mode status out.
interface led_scan_if;
   logic       KEY1;
   logic       KEY2;
   logic [9:0] SW;
   logic [7:0] LEDG;
   logic       step;
   logic       dir;
   logic [1:0] mode;

   modport master (output KEY1, KEY2, SW, input LEDG, step, dir, mode);
   modport slave  (input KEY1, KEY2, SW, output LEDG, step, dir, mode);
endinterface

// File: rtl/led_scan_scheduler_key_debounce.sv
// Raw push-button conditioner: 2-FF synchronizer, stability counter and a
// one-cycle pulse on each accepted press (high-to-low transition).
module key_debounce #(
   parameter int DEBOUNCE = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE + 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic [CW-1:0] count;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours; blocking here would collapse the
   // synchronizer into a single stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         level <= 1'b1;
         count <= '0;
         press <= 1'b0;
      end else begin
         sync1 <= key;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 == level) begin
            count <= '0;
         end else if (count == CW'(DEBOUNCE - 1)) begin
            count <= '0;
            level <= sync2;
            press <= ~sync2;
         end else begin
            count <= count + CW'(1);
         end
      end
   end

endmodule

// File: rtl/led_scan_scheduler.sv
// LEDG one-hot scanner controller: SW-selected step timebase, debounced
// pause/mode keys and the mode FSM that sequences the LED pattern.
module led_scan_scheduler
   import led_pkg::*;
#(
   parameter int BASE_DIV = 1000000,
   parameter int DEBOUNCE = 500000,
   parameter int CNT_W    = 26
) (
   input  logic          CLOCK_50,
   input  logic          KEY0,
   led_scan_if.slave     bus
);

   logic             pause_press;
   logic             mode_press;
   logic [CNT_W-1:0] limit_q, limit_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             step_q, step_d;
   logic [7:0]       led_q, led_d;
   logic             dir_q, dir_d;
   mode_t            mode_q, mode_d;
   mode_t            saved_q, saved_d;
   logic             tick;

   key_debounce #(.DEBOUNCE(DEBOUNCE)) u_pause_key (
      .clk   (CLOCK_50),
      .rst_n (KEY0),
      .key   (bus.KEY1),
      .press (pause_press)
   );

   key_debounce #(.DEBOUNCE(DEBOUNCE)) u_mode_key (
      .clk   (CLOCK_50),
      .rst_n (KEY0),
      .key   (bus.KEY2),
      .press (mode_press)
   );

   // Lowest set switch index wins, so scan from the top and let lower ones override.
   always_comb begin
      limit_d = CNT_W'(BASE_DIV * DEFAULT_MULT);
      for (int i = 9; i >= 0; i--) begin
         if (bus.SW[i]) limit_d = CNT_W'(BASE_DIV * SPEED_MULT[i]);
      end
   end

   // >= rather than == so a freshly lowered limit below cnt fires at once.
   assign tick = (mode_q != MODE_PAUSED) && (cnt_q >= limit_q - CNT_W'(1));

   // NOTE: every variable gets its default before any branch so no path
   // leaves one unassigned; otherwise synthesis infers a latch.
   always_comb begin
      mode_d  = mode_q;
      saved_d = saved_q;
      if (pause_press) begin
         if (mode_q == MODE_PAUSED) begin
            mode_d = saved_q;
         end else begin
            saved_d = mode_q;
            mode_d  = MODE_PAUSED;
         end
      end else if (mode_press && mode_q != MODE_PAUSED) begin
         mode_d = next_run_mode(mode_q);
      end
   end

   always_comb begin
      cnt_d  = cnt_q;
      step_d = tick;
      led_d  = led_q;
      dir_d  = dir_q;
      if (mode_q != MODE_PAUSED) cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
      if (tick) begin
         if (!is_one_hot(led_q)) begin
            led_d = LED_RESET;
            dir_d = 1'b0;
         end else begin
            case (mode_q)
               MODE_BOUNCE: begin
                  // Turn around at the ends without dwelling there.
                  if (!dir_q) begin
                     if (led_q[7]) begin
                        led_d = led_q >> 1;
                        dir_d = 1'b1;
                     end else begin
                        led_d = led_q << 1;
                     end
                  end else begin
                     if (led_q[0]) begin
                        led_d = led_q << 1;
                        dir_d = 1'b0;
                     end else begin
                        led_d = led_q >> 1;
                     end
                  end
               end
               MODE_ROT_L: led_d = {led_q[6:0], led_q[7]};
               MODE_ROT_R: led_d = {led_q[0], led_q[7:1]};
               default:    led_d = led_q;
            endcase
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge KEY0) begin
      if (!KEY0) begin
         limit_q <= CNT_W'(BASE_DIV * DEFAULT_MULT);
         cnt_q   <= '0;
         step_q  <= 1'b0;
         led_q   <= LED_RESET;
         dir_q   <= 1'b0;
         mode_q  <= MODE_BOUNCE;
         saved_q <= MODE_BOUNCE;
      end else begin
         limit_q <= limit_d;
         cnt_q   <= cnt_d;
         step_q  <= step_d;
         led_q   <= led_d;
         dir_q   <= dir_d;
         mode_q  <= mode_d;
         saved_q <= saved_d;
      end
   end

   assign bus.LEDG = led_q;
   assign bus.step = step_q;
   assign bus.dir  = dir_q;
   assign bus.mode = mode_q;

endmodule

// File: tb/tb_led_scan_scheduler.sv
// Self-checking bench for led_scan_scheduler with BASE_DIV=4, DEBOUNCE=3:
// cycle model compared every cycle plus directed literal expectations.
module tb_led_scan_scheduler;

   localparam int BASE_DIV = 4;
   localparam int DEBOUNCE = 3;
   localparam int CNT_W    = 26;

   logic clk  = 1'b0;
   logic KEY0 = 1'b0;

   led_scan_if bus ();

   led_scan_scheduler #(
      .BASE_DIV (BASE_DIV),
      .DEBOUNCE (DEBOUNCE),
      .CNT_W    (CNT_W)
   ) dut (
      .CLOCK_50 (clk),
      .KEY0     (KEY0),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0]        m_led;
   bit                m_dir, m_step;
   int                m_mode, m_saved, m_cnt, m_limit;
   logic [DEBOUNCE:0] line1, line2;   // line[0] = raw key seen one edge ago
   bit                acc1, acc2, pend_pause, pend_mode, np1, np2, tick;
   int                pos;

   function automatic int lim_of(input logic [9:0] sw);
      for (int i = 0; i < 10; i++) if (sw[i]) return BASE_DIV * (10 - i);
      return BASE_DIV * 11;
   endfunction

   always @(posedge clk or negedge KEY0) begin
      if (!KEY0) begin
         m_led = 8'h01; m_dir = 0; m_step = 0; m_mode = 0; m_saved = 0;
         m_cnt = 0; m_limit = BASE_DIV * 11;
         line1 = '1; line2 = '1; acc1 = 1; acc2 = 1;
         pend_pause = 0; pend_mode = 0;
      end else begin
         tick   = (m_mode != 3) && (m_cnt >= m_limit - 1);
         m_step = tick;
         if (m_mode != 3) m_cnt = tick ? 0 : m_cnt + 1;
         if (tick) begin
            if ($countones(m_led) != 1) begin
               m_led = 8'h01; m_dir = 0;
            end else begin
               pos = $clog2(m_led);
               case (m_mode)
                  0: if (!m_dir) begin
                        if (pos == 7) begin pos = 6; m_dir = 1; end else pos++;
                     end else begin
                        if (pos == 0) begin pos = 1; m_dir = 0; end else pos--;
                     end
                  1: pos = (pos + 1) % 8;
                  2: pos = (pos + 7) % 8;
                  default: ;
               endcase
               m_led = 8'(1 << pos);
            end
         end
         if (pend_pause) begin
            if (m_mode == 3) m_mode = m_saved;
            else begin m_saved = m_mode; m_mode = 3; end
         end else if (pend_mode && m_mode != 3) begin
            m_mode = (m_mode + 1) % 3;
         end
         m_limit = lim_of(bus.SW);
         // A level is accepted once DEBOUNCE consecutive synchronized samples disagree with it.
         np1 = 0; np2 = 0;
         if (line1[DEBOUNCE:1] == {DEBOUNCE{~acc1}}) begin acc1 = ~acc1; np1 = !acc1; end
         if (line2[DEBOUNCE:1] == {DEBOUNCE{~acc2}}) begin acc2 = ~acc2; np2 = !acc2; end
         line1 = {line1[DEBOUNCE-1:0], bus.KEY1};
         line2 = {line2[DEBOUNCE-1:0], bus.KEY2};
         pend_pause = np1;
         pend_mode  = np2;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("cmp_ledg", bus.LEDG, m_led);
         check("cmp_step", bus.step, m_step);
         check("cmp_dir",  bus.dir,  m_dir);
         check("cmp_mode", bus.mode, m_mode);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic wait_step(input int budget, output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (bus.step !== 1'b1 && cycles < budget);
      if (bus.step !== 1'b1) begin
         n_checks++;
         n_errors++;
         $display("FAIL step_timeout: no step within %0d cycles at %0t", budget, $time);
      end
   endtask

   task automatic press_mode_key(input int hold);
      bus.KEY2 = 1'b0;
      repeat (hold) @(negedge clk);
      bus.KEY2 = 1'b1;
   endtask

   logic [7:0]  bounce_exp [0:14];
   logic [14:0] dir_exp;
   logic [7:0]  rotl_exp   [0:4];

   initial begin
      int c;
      int bad;
      bounce_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                     8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
      dir_exp    = 15'b011_1111_1000_0000;   // bit s = dir after step s
      rotl_exp   = '{8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

      bus.KEY1 = 1'b1;
      bus.KEY2 = 1'b1;
      bus.SW   = '0;
      KEY0     = 1'b0;
      repeat (3) @(negedge clk);
      cmp_en = 1'b1;
      check("rst_ledg", bus.LEDG, 8'h01);
      check("rst_dir",  bus.dir,  1'b0);
      check("rst_mode", bus.mode, 2'd0);
      check("rst_step", bus.step, 1'b0);
      KEY0 = 1'b1;

      // Bounce at the default 11*BASE_DIV period.
      for (int s = 0; s < 15; s++) begin
         wait_step(100, c);
         check("bounce_period", c, 44);
         check("bounce_ledg", bus.LEDG, bounce_exp[s]);
         check("bounce_dir", bus.dir, dir_exp[s]);
      end

      // SW[3] gives 28 cycles; SW[9] with cnt=20 fires after the limit register updates.
      bus.SW = 10'b00_0000_1000;
      wait_step(100, c); check("sw3_period", c, 28);
      wait_step(100, c); check("sw3_period", c, 28);
      repeat (20) @(negedge clk);
      bus.SW = 10'b10_0000_0000;
      wait_step(100, c); check("sw9_immediate", c, 2);
      wait_step(100, c); check("sw9_period", c, 4);
      wait_step(100, c); check("sw9_period", c, 4);

      // Mode key during bounce at 08, then ROT_R after 01.
      bus.SW = '0;
      for (int n = 0; n < 20 && bus.LEDG !== 8'h08; n++) wait_step(100, c);
      check("reach_08", bus.LEDG, 8'h08);
      press_mode_key(8);
      check("mode_rotl", bus.mode, 2'd1);
      for (int s = 0; s < 5; s++) begin
         wait_step(100, c);
         check("rotl_ledg", bus.LEDG, rotl_exp[s]);
      end
      press_mode_key(8);
      check("mode_rotr", bus.mode, 2'd2);
      wait_step(100, c); check("rotr_ledg", bus.LEDG, 8'h80);
      wait_step(100, c); check("rotr_ledg", bus.LEDG, 8'h40);

      // Pause 10 cycles after a step: mode flips DEBOUNCE+3 edges after the key drops.
      repeat (10) @(negedge clk);
      bus.KEY1 = 1'b0;
      repeat (DEBOUNCE + 2) @(negedge clk);
      check("pause_not_early", bus.mode, 2'd2);
      @(negedge clk);
      check("pause_applied", bus.mode, 2'd3);
      repeat (2) @(negedge clk);
      bus.KEY1 = 1'b1;
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (i == 50) bus.KEY2 = 1'b0;
         if (i == 58) bus.KEY2 = 1'b1;
         if (bus.step !== 1'b0 || bus.LEDG !== 8'h40 || bus.mode !== 2'd3) bad++;
      end
      check("pause_frozen", bad, 0);

      // Held cnt is 16, so the first step lands 44-16 cycles after the mode restores.
      bus.KEY1 = 1'b0;
      repeat (DEBOUNCE + 3) @(negedge clk);
      check("resume_mode", bus.mode, 2'd2);
      repeat (2) @(negedge clk);
      bus.KEY1 = 1'b1;
      wait_step(100, c);
      check("resume_remaining", c + 2, 28);
      check("resume_ledg", bus.LEDG, 8'h20);

      // Short glitch, then simultaneous pause+mode presses.
      bus.KEY1 = 1'b0;
      repeat (2) @(negedge clk);
      bus.KEY1 = 1'b1;
      repeat (10) @(negedge clk);
      check("glitch_ignored", bus.mode, 2'd2);
      bus.KEY1 = 1'b0;
      bus.KEY2 = 1'b0;
      repeat (DEBOUNCE + 3) @(negedge clk);
      check("pause_wins", bus.mode, 2'd3);
      repeat (2) @(negedge clk);
      bus.KEY1 = 1'b1;
      bus.KEY2 = 1'b1;
      repeat (10) @(negedge clk);
      bus.KEY1 = 1'b0;
      repeat (DEBOUNCE + 3) @(negedge clk);
      check("saved_mode_kept", bus.mode, 2'd2);
      repeat (2) @(negedge clk);
      bus.KEY1 = 1'b1;
      repeat (8) @(negedge clk);

      // ROT_R -> BOUNCE -> ROT_L, then async reset while LEDG=20.
      press_mode_key(8);
      repeat (8) @(negedge clk);
      press_mode_key(8);
      repeat (8) @(negedge clk);
      check("mode_rotl_again", bus.mode, 2'd1);
      for (int n = 0; n < 20 && bus.LEDG !== 8'h20; n++) wait_step(100, c);
      check("reach_20", bus.LEDG, 8'h20);
      repeat (10) @(negedge clk);
      #2 KEY0 = 1'b0;
      #1;
      check("async_rst_ledg", bus.LEDG, 8'h01);
      check("async_rst_mode", bus.mode, 2'd0);
      check("async_rst_dir",  bus.dir,  1'b0);
      check("async_rst_step", bus.step, 1'b0);
      repeat (3) @(negedge clk);
      KEY0 = 1'b1;
      wait_step(100, c);
      check("restart_period", c, 44);
      check("restart_ledg", bus.LEDG, 8'h02);
      check("restart_mode", bus.mode, 2'd0);

      @(negedge clk);
      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
